// File: rtl/id_ex_ctrl_stage_if.sv
// ID/EX control-stage bus: decode-side control bundle in, registered EX-side bundle,
// stall request and debug counters out.
interface id_ex_ctrl_stage_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [1:0]            id_alu_op;
  logic                  id_reg_dst, id_branch, id_mem_read, id_mem_2_reg;
  logic                  id_mem_write, id_alu_src, id_reg_write, id_jump;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic                  ex_flush;

  logic                  stall;
  logic                  ex_valid;
  logic [1:0]            ex_alu_op;
  logic                  ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic                  ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_opcode, id_alu_op, id_reg_dst, id_branch, id_mem_read,
           id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump,
           id_rs1, id_rs2, id_rd, ex_flush,
    input  stall, ex_valid, ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read,
           ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
           ex_rs1, ex_rs2, ex_rd, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_alu_op, id_reg_dst, id_branch, id_mem_read,
           id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump,
           id_rs1, id_rs2, id_rd, ex_flush,
    output stall, ex_valid, ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read,
           ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
           ex_rs1, ex_rs2, ex_rd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the control bundle, with load-use stall detection,
// bubble insertion on stall/flush and saturating stall/flush counters.
module id_ex_ctrl_stage #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic                clk,
  input logic                arst_n,
  id_ex_ctrl_stage_if.slave  bus
);

  typedef enum logic [6:0] {
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  opcode_e               id_op;
  ctrl_t                 id_ctrl;
  ctrl_t                 ex_ctrl;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;
  logic                  uses_rs1, uses_rs2, hazard, stall;

  always_comb begin
    id_op   = opcode_e'(bus.id_opcode);
    id_ctrl = '{alu_op:    bus.id_alu_op,
                reg_dst:   bus.id_reg_dst,
                branch:    bus.id_branch,
                mem_read:  bus.id_mem_read,
                mem_2_reg: bus.id_mem_2_reg,
                mem_write: bus.id_mem_write,
                alu_src:   bus.id_alu_src,
                reg_write: bus.id_reg_write,
                jump:      bus.id_jump};
  end

  // A flush discards the ID instruction, so the hazard it would cause is moot.
  always_comb begin
    uses_rs1 = (id_op != OP_JAL);
    uses_rs2 = (id_op == OP_RTYPE) || (id_op == OP_BRANCH) || (id_op == OP_STORE);
    hazard   = bus.id_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
               ((uses_rs1 && (ex_rd == bus.id_rs1)) || (uses_rs2 && (ex_rd == bus.id_rs2)));
    stall    = hazard && !bus.ex_flush;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.ex_flush || stall) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        ex_rd    <= '0;
      end else begin
        ex_valid <= bus.id_valid;
        ex_ctrl  <= bus.id_valid ? id_ctrl : '0;
        ex_rs1   <= bus.id_rs1;
        ex_rs2   <= bus.id_rs2;
        ex_rd    <= bus.id_rd;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.ex_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_valid     = ex_valid;
  assign bus.ex_alu_op    = ex_ctrl.alu_op;
  assign bus.ex_reg_dst   = ex_ctrl.reg_dst;
  assign bus.ex_branch    = ex_ctrl.branch;
  assign bus.ex_mem_read  = ex_ctrl.mem_read;
  assign bus.ex_mem_2_reg = ex_ctrl.mem_2_reg;
  assign bus.ex_mem_write = ex_ctrl.mem_write;
  assign bus.ex_alu_src   = ex_ctrl.alu_src;
  assign bus.ex_reg_write = ex_ctrl.reg_write;
  assign bus.ex_jump      = ex_ctrl.jump;
  assign bus.ex_rs1       = ex_rs1;
  assign bus.ex_rs2       = ex_rs2;
  assign bus.ex_rd        = ex_rd;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: directed vectors push hand-computed
// expectations; a monitor checks pre-edge stall and post-edge registered state.
module tb_id_ex_ctrl_stage;

  logic clk;
  logic arst_n;

  id_ex_ctrl_stage_if #(.REG_ADDR_W(5), .CNT_W(4)) bus ();

  id_ex_ctrl_stage #(.REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl bit order: {reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [6:0] op;
    logic [1:0] alu;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       flush;
  } vec_t;

  typedef struct {
    string      tag;
    logic       stall;
    logic       valid;
    logic [1:0] alu;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t ins(logic [6:0] op, logic [1:0] alu, logic [7:0] ctrl,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    vec_t v;
    v.rst_n = 1'b1; v.valid = 1'b1; v.op = op; v.alu = alu; v.ctrl = ctrl;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.flush = 1'b0;
    return v;
  endfunction

  function automatic exp_t cap(string tag, vec_t v, logic st, logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.tag = tag; e.stall = st; e.valid = 1'b1; e.alu = v.alu; e.ctrl = v.ctrl;
    e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  function automatic exp_t bub(string tag, logic st, logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.tag = tag; e.stall = st; e.valid = 1'b0; e.alu = '0; e.ctrl = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic step(input vec_t v, input exp_t e, input bit chk);
    @(negedge clk);
    arst_n           = v.rst_n;
    bus.id_valid     = v.valid;
    bus.id_opcode    = v.op;
    bus.id_alu_op    = v.alu;
    {bus.id_reg_dst, bus.id_branch, bus.id_mem_read, bus.id_mem_2_reg,
     bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_jump} = v.ctrl;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.ex_flush     = v.flush;
    if (chk) q.push_back(e);
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // Monitor: stall sampled just before the rising edge, registers just after it.
  initial begin
    logic       s;
    logic [7:0] act_ctrl;
    exp_t       e;
    forever begin
      @(negedge clk);
      #4;
      s = bus.stall;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act_ctrl = {bus.ex_reg_dst, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_2_reg,
                    bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write, bus.ex_jump};
        chk(e.tag, "stall",     32'(s),             32'(e.stall));
        chk(e.tag, "ex_valid",  32'(bus.ex_valid),  32'(e.valid));
        chk(e.tag, "ex_alu_op", 32'(bus.ex_alu_op), 32'(e.alu));
        chk(e.tag, "ex_ctrl",   32'(act_ctrl),      32'(e.ctrl));
        chk(e.tag, "ex_rs1",    32'(bus.ex_rs1),    32'(e.rs1));
        chk(e.tag, "ex_rs2",    32'(bus.ex_rs2),    32'(e.rs2));
        chk(e.tag, "ex_rd",     32'(bus.ex_rd),     32'(e.rd));
        chk(e.tag, "stall_cnt", 32'(bus.stall_cnt), 32'(e.sc));
        chk(e.tag, "flush_cnt", 32'(bus.flush_cnt), 32'(e.fc));
      end
    end
  end

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  initial begin
    vec_t       all1, rt, lw5, add, lw0, add0, jal, sw, inv, v;
    logic [3:0] sc, sc_n;

    all1 = ins(OPC_R,   2'b11, 8'hFF, 5'd5, 5'd5, 5'd5);
    rt   = ins(OPC_R,   2'b10, 8'h82, 5'd1, 5'd2, 5'd5);
    lw5  = ins(OPC_LD,  2'b00, 8'h36, 5'd1, 5'd0, 5'd5);
    add  = ins(OPC_R,   2'b10, 8'h82, 5'd5, 5'd7, 5'd6);
    lw0  = ins(OPC_LD,  2'b00, 8'h36, 5'd1, 5'd0, 5'd0);
    add0 = ins(OPC_R,   2'b10, 8'h82, 5'd0, 5'd7, 5'd6);
    jal  = ins(OPC_JAL, 2'b00, 8'h03, 5'd5, 5'd5, 5'd1);
    sw   = ins(OPC_ST,  2'b00, 8'h0C, 5'd2, 5'd5, 5'd0);
    inv  = ins(OPC_R,   2'b11, 8'hFF, 5'd3, 5'd4, 5'd9);
    inv.valid = 1'b0;

    // Reset with every control input high; first edge leaves no known prior state to check.
    v = all1; v.rst_n = 1'b0;
    step(v, bub("rst0", 1'b0, 4'd0, 4'd0), 1'b0);
    step(v, bub("rst1", 1'b0, 4'd0, 4'd0), 1'b1);
    step(v, bub("rst2", 1'b0, 4'd0, 4'd0), 1'b1);
    step(all1, cap("release", all1, 1'b0, 4'd0, 4'd0), 1'b1);

    step(rt,   cap("rtype",   rt,   1'b0, 4'd0, 4'd0), 1'b1);
    step(lw5,  cap("lw5_a",   lw5,  1'b0, 4'd0, 4'd0), 1'b1);
    step(add,  bub("loaduse", 1'b1, 4'd1, 4'd0),       1'b1);
    step(add,  cap("add_re",  add,  1'b0, 4'd1, 4'd0), 1'b1);
    step(lw0,  cap("lw0",     lw0,  1'b0, 4'd1, 4'd0), 1'b1);
    step(add0, cap("x0",      add0, 1'b0, 4'd1, 4'd0), 1'b1);
    step(lw5,  cap("lw5_b",   lw5,  1'b0, 4'd1, 4'd0), 1'b1);
    step(jal,  cap("jal",     jal,  1'b0, 4'd1, 4'd0), 1'b1);
    step(lw5,  cap("lw5_c",   lw5,  1'b0, 4'd1, 4'd0), 1'b1);
    step(sw,   bub("store",   1'b1, 4'd2, 4'd0),       1'b1);
    step(sw,   cap("sw_re",   sw,   1'b0, 4'd2, 4'd0), 1'b1);
    step(lw5,  cap("lw5_d",   lw5,  1'b0, 4'd2, 4'd0), 1'b1);
    v = add; v.flush = 1'b1;
    step(v,    bub("flush_hz", 1'b0, 4'd2, 4'd1),      1'b1);

    // Invalid slot: indices captured, all control forced low.
    begin
      exp_t e;
      e = bub("invalid", 1'b0, 4'd2, 4'd1);
      e.rs1 = 5'd3; e.rs2 = 5'd4; e.rd = 5'd9;
      step(inv, e, 1'b1);
    end
    v = inv; v.flush = 1'b1;
    step(v, bub("flush_inv", 1'b0, 4'd2, 4'd2), 1'b1);

    // Drive stall_cnt from 2 up to all-ones, then one more stall must hold at 4'hF.
    sc = 4'd2;
    for (int i = 0; i < 14; i++) begin
      sc_n = (sc == 4'hF) ? sc : sc + 4'd1;
      step(lw5, cap("sat_lw",  lw5, 1'b0, sc, 4'd2), 1'b1);
      step(add, bub("sat_st",  1'b1, sc_n, 4'd2),    1'b1);
      sc = sc_n;
      step(add, cap("sat_add", add, 1'b0, sc, 4'd2), 1'b1);
    end

    step(lw5, cap("pre_rst", lw5, 1'b0, 4'hF, 4'd2), 1'b1);
    v = add; v.rst_n = 1'b0;
    step(v,   bub("rst_mid", 1'b1, 4'd0, 4'd0),      1'b1);
    step(add, cap("post_rst", add, 1'b0, 4'd0, 4'd0), 1'b1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
